// File: rtl/bus_control_sequencer_if.sv
// CPU-side bus pins of the 8259A-style bus control sequencer.
// The CPU (or bench) drives the strobes and write data; the sequencer returns read data.
interface bus_control_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  CS_bar;
    logic                  RD_bar;
    logic                  WR_bar;
    logic                  A0;
    logic [DATA_WIDTH-1:0] data_bus_in;
    logic [DATA_WIDTH-1:0] data_bus_out;
    logic                  data_bus_oe;

    modport master (
        output CS_bar, RD_bar, WR_bar, A0, data_bus_in,
        input  data_bus_out, data_bus_oe
    );

    modport slave (
        input  CS_bar, RD_bar, WR_bar, A0, data_bus_in,
        output data_bus_out, data_bus_oe
    );
endinterface

// File: rtl/bus_control_sequencer.sv
// Clocked 8259A bus control: write capture, ICW/OCW decode, init FSM and read-back mux.
// Optional poll-command support is enabled by defining BUS_CTRL_POLL_EN.
module bus_control_sequencer #(
    parameter int unsigned          DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] IMR_RESET = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_control_sequencer_if.slave bus,
    input  logic [DATA_WIDTH-1:0] irr_in,
    input  logic [DATA_WIDTH-1:0] isr_in,
    input  logic [DATA_WIDTH-1:0] poll_word_in,
    output logic                  icw1_wr,
    output logic                  icw2_wr,
    output logic                  icw3_wr,
    output logic                  icw4_wr,
    output logic                  ocw1_wr,
    output logic                  ocw2_wr,
    output logic                  ocw3_wr,
    output logic                  init_done,
    output logic                  ltim,
    output logic                  single,
    output logic                  ic4,
    output logic                  aeoi,
    output logic [4:0]            vector_base,
    output logic [DATA_WIDTH-1:0] cascade_cfg,
    output logic [DATA_WIDTH-1:0] imr,
    output logic [DATA_WIDTH-1:0] ocw2_cmd,
    output logic                  special_mask,
    output logic                  poll_ack
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } state_t;

    typedef enum logic {
        SEL_IRR,
        SEL_ISR
    } read_sel_t;

    state_t                state_q;
    state_t                state_d;
    read_sel_t             read_sel;

    logic                  wr_active;
    logic                  wr_active_q;
    logic                  commit;
    logic                  a0_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  poll_pending;

    logic                  icw1_hit;
    logic                  icw2_hit;
    logic                  icw3_hit;
    logic                  icw4_hit;
    logic                  ocw1_hit;
    logic                  ocw2_hit;
    logic                  ocw3_hit;

    // ------------------------------------------------------------------
    // Write capture: the last data seen while the write is active commits
    // on the trailing edge of the combined CS/WR strobe.
    // ------------------------------------------------------------------
    assign wr_active = ~bus.CS_bar & ~bus.WR_bar;
    assign commit    = wr_active_q & ~wr_active;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_active_q <= 1'b0;
            a0_q        <= 1'b0;
            data_q      <= '0;
        end else begin
            wr_active_q <= wr_active;
            if (wr_active) begin
                a0_q   <= bus.A0;
                data_q <= bus.data_bus_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Initialisation FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (icw1_hit) begin
            state_d = WAIT_ICW2;
        end else if (icw2_hit) begin
            if (!single) begin
                state_d = WAIT_ICW3;
            end else if (ic4) begin
                state_d = WAIT_ICW4;
            end else begin
                state_d = READY;
            end
        end else if (icw3_hit) begin
            state_d = ic4 ? WAIT_ICW4 : READY;
        end else if (icw4_hit) begin
            state_d = READY;
        end
    end

    // ICW1 is recognised in every state, so it must mask every other decode.
    always_comb begin
        icw1_hit = commit & ~a0_q & data_q[4];
        icw2_hit = commit & a0_q & (state_q == WAIT_ICW2);
        icw3_hit = commit & a0_q & (state_q == WAIT_ICW3);
        icw4_hit = commit & a0_q & (state_q == WAIT_ICW4);
        ocw1_hit = commit & a0_q & (state_q == READY);
        ocw2_hit = commit & ~a0_q & ~data_q[4] & ~data_q[3] & (state_q == READY);
        ocw3_hit = commit & ~a0_q & ~data_q[4] &  data_q[3] & (state_q == READY);
    end

    assign init_done = (state_q == READY);

    // ------------------------------------------------------------------
    // Command-word registers and one-cycle commit strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            icw1_wr      <= 1'b0;
            icw2_wr      <= 1'b0;
            icw3_wr      <= 1'b0;
            icw4_wr      <= 1'b0;
            ocw1_wr      <= 1'b0;
            ocw2_wr      <= 1'b0;
            ocw3_wr      <= 1'b0;
            ltim         <= 1'b0;
            single       <= 1'b0;
            ic4          <= 1'b0;
            aeoi         <= 1'b0;
            vector_base  <= '0;
            cascade_cfg  <= '0;
            imr          <= IMR_RESET;
            ocw2_cmd     <= '0;
            special_mask <= 1'b0;
            read_sel     <= SEL_IRR;
        end else begin
            icw1_wr <= icw1_hit;
            icw2_wr <= icw2_hit;
            icw3_wr <= icw3_hit;
            icw4_wr <= icw4_hit;
            ocw1_wr <= ocw1_hit;
            ocw2_wr <= ocw2_hit;
            ocw3_wr <= ocw3_hit;

            if (icw1_hit) begin
                ltim         <= data_q[3];
                single       <= data_q[1];
                ic4          <= data_q[0];
                imr          <= IMR_RESET;
                aeoi         <= 1'b0;
                special_mask <= 1'b0;
                read_sel     <= SEL_IRR;
            end
            if (icw2_hit) begin
                vector_base <= data_q[7:3];
            end
            if (icw3_hit) begin
                cascade_cfg <= data_q;
            end
            if (icw4_hit) begin
                aeoi <= data_q[1];
            end
            if (ocw1_hit) begin
                imr <= data_q;
            end
            if (ocw2_hit) begin
                ocw2_cmd <= data_q;
            end
            if (ocw3_hit) begin
                if (data_q[1]) begin
                    read_sel <= data_q[0] ? SEL_ISR : SEL_IRR;
                end
                if (data_q[6]) begin
                    special_mask <= data_q[5];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Poll command
    // ------------------------------------------------------------------
`ifdef BUS_CTRL_POLL_EN
    logic oe_q;

    // The poll completes on the falling edge of the read enable, not on RD_bar alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            oe_q         <= 1'b0;
            poll_pending <= 1'b0;
            poll_ack     <= 1'b0;
        end else begin
            oe_q     <= bus.data_bus_oe;
            poll_ack <= 1'b0;
            if (oe_q && !bus.data_bus_oe && poll_pending) begin
                poll_pending <= 1'b0;
                poll_ack     <= 1'b1;
            end
            if (icw1_hit) begin
                poll_pending <= 1'b0;
            end else if (ocw3_hit && data_q[2]) begin
                poll_pending <= 1'b1;
            end
        end
    end
`else
    logic unused_poll_word;

    assign poll_pending     = 1'b0;
    assign poll_ack         = 1'b0;
    assign unused_poll_word = ^poll_word_in;
`endif

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    assign bus.data_bus_oe = ~bus.CS_bar & ~bus.RD_bar & bus.WR_bar;

    always_comb begin
        bus.data_bus_out = '0;
        if (bus.data_bus_oe) begin
`ifdef BUS_CTRL_POLL_EN
            if (poll_pending) begin
                bus.data_bus_out = poll_word_in;
            end else
`endif
            if (bus.A0) begin
                bus.data_bus_out = imr;
            end else if (read_sel == SEL_ISR) begin
                bus.data_bus_out = isr_in;
            end else begin
                bus.data_bus_out = irr_in;
            end
        end
    end

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Directed self-checking bench for bus_control_sequencer.
// The poll scenario runs only when BUS_CTRL_POLL_EN is defined.
module tb_bus_control_sequencer;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] irr_in;
    logic [DW-1:0] isr_in;
    logic [DW-1:0] poll_word_in;
    logic          icw1_wr, icw2_wr, icw3_wr, icw4_wr;
    logic          ocw1_wr, ocw2_wr, ocw3_wr;
    logic          init_done, ltim, single, ic4, aeoi;
    logic [4:0]    vector_base;
    logic [DW-1:0] cascade_cfg, imr, ocw2_cmd;
    logic          special_mask, poll_ack;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [6:0]    stb;
    logic [DW-1:0] rd_data;
    logic          rd_oe;

    bus_control_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    bus_control_sequencer #(
        .DATA_WIDTH(DW),
        .IMR_RESET (8'h5A)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .irr_in      (irr_in),
        .isr_in      (isr_in),
        .poll_word_in(poll_word_in),
        .icw1_wr     (icw1_wr),
        .icw2_wr     (icw2_wr),
        .icw3_wr     (icw3_wr),
        .icw4_wr     (icw4_wr),
        .ocw1_wr     (ocw1_wr),
        .ocw2_wr     (ocw2_wr),
        .ocw3_wr     (ocw3_wr),
        .init_done   (init_done),
        .ltim        (ltim),
        .single      (single),
        .ic4         (ic4),
        .aeoi        (aeoi),
        .vector_base (vector_base),
        .cascade_cfg (cascade_cfg),
        .imr         (imr),
        .ocw2_cmd    (ocw2_cmd),
        .special_mask(special_mask),
        .poll_ack    (poll_ack)
    );

    always #5 clk = ~clk;

    // Strobe bit order: {icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3}
    assign stb = {icw1_wr, icw2_wr, icw3_wr, icw4_wr, ocw1_wr, ocw2_wr, ocw3_wr};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Returns #1 after the commit edge, i.e. while the strobe should be high.
    task automatic cpu_write(input logic a0, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        bus.A0          = a0;
        bus.data_bus_in = d;
        bus.CS_bar      = 1'b0;
        bus.WR_bar      = 1'b0;
        @(posedge clk);
        #1;
        bus.WR_bar = 1'b1;
        bus.CS_bar = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic a0, output logic [DW-1:0] d, output logic oe);
        @(posedge clk);
        #1;
        bus.A0     = a0;
        bus.CS_bar = 1'b0;
        bus.RD_bar = 1'b0;
        #2;
        d  = bus.data_bus_out;
        oe = bus.data_bus_oe;
        @(posedge clk);
        #1;
        bus.RD_bar = 1'b1;
        bus.CS_bar = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.CS_bar      = 1'b1;
        bus.RD_bar      = 1'b1;
        bus.WR_bar      = 1'b1;
        bus.A0          = 1'b0;
        bus.data_bus_in = '0;
        irr_in          = 8'h81;
        isr_in          = 8'h40;
        poll_word_in    = 8'h83;
        reset           = 1'b0;

        // 1: reset values, single-mode init with ICW4
        do_reset();
        check("rst_strobes", 32'(stb), 32'h00);
        check("rst_init_done", 32'(init_done), 32'h0);
        check("rst_imr", 32'(imr), 32'h5A);
        check("rst_oe", 32'(bus.data_bus_oe), 32'h0);
        check("rst_dout", 32'(bus.data_bus_out), 32'h00);

        cpu_write(1'b0, 8'h13);
        check("t1_icw1_stb", 32'(stb), 32'h40);
        check("t1_flags", 32'({ltim, single, ic4}), 32'h3);
        @(posedge clk);
        #1;
        check("t1_stb_width", 32'(stb), 32'h00);
        cpu_write(1'b1, 8'h20);
        check("t1_icw2_stb", 32'(stb), 32'h20);
        check("t1_vector", 32'(vector_base), 32'h04);
        check("t1_not_ready", 32'(init_done), 32'h0);
        cpu_write(1'b1, 8'h03);
        check("t1_icw4_stb", 32'(stb), 32'h08);
        check("t1_aeoi", 32'(aeoi), 32'h1);
        check("t1_init_done", 32'(init_done), 32'h1);

        // 2: cascade init with ICW3, then OCW1 and readback
        cpu_write(1'b0, 8'h11);
        check("t2_icw1_stb", 32'(stb), 32'h40);
        cpu_write(1'b1, 8'h08);
        check("t2_icw2_stb", 32'(stb), 32'h20);
        cpu_write(1'b1, 8'h04);
        check("t2_icw3_stb", 32'(stb), 32'h10);
        check("t2_cascade", 32'(cascade_cfg), 32'h04);
        cpu_write(1'b1, 8'h01);
        check("t2_icw4_stb", 32'(stb), 32'h08);
        check("t2_aeoi", 32'(aeoi), 32'h0);
        check("t2_ready", 32'(init_done), 32'h1);
        cpu_write(1'b1, 8'hA5);
        check("t2_ocw1_stb", 32'(stb), 32'h04);
        check("t2_imr", 32'(imr), 32'hA5);
        cpu_read(1'b1, rd_data, rd_oe);
        check("t2_rd_imr", 32'(rd_data), 32'hA5);
        check("t2_rd_oe", 32'(rd_oe), 32'h1);

        // Read and write strobes together: write wins, bus not driven
        @(posedge clk);
        #1;
        bus.A0          = 1'b1;
        bus.data_bus_in = 8'hA5;
        bus.CS_bar      = 1'b0;
        bus.RD_bar      = 1'b0;
        bus.WR_bar      = 1'b0;
        #1;
        check("t2_rdwr_oe", 32'(bus.data_bus_oe), 32'h0);
        check("t2_rdwr_dout", 32'(bus.data_bus_out), 32'h00);
        @(posedge clk);
        #1;
        bus.CS_bar = 1'b1;
        bus.RD_bar = 1'b1;
        bus.WR_bar = 1'b1;
        @(posedge clk);

        // 3: OCW3 read select, OCW2, special mask
        cpu_write(1'b0, 8'h0B);
        check("t3_ocw3_stb", 32'(stb), 32'h01);
        cpu_read(1'b0, rd_data, rd_oe);
        check("t3_rd_isr", 32'(rd_data), 32'h40);
        cpu_write(1'b0, 8'h0A);
        cpu_read(1'b0, rd_data, rd_oe);
        check("t3_rd_irr", 32'(rd_data), 32'h81);
        cpu_write(1'b0, 8'h68);
        check("t3_smm", 32'(special_mask), 32'h1);
        cpu_write(1'b0, 8'h20);
        check("t3_ocw2_stb", 32'(stb), 32'h02);
        check("t3_ocw2_cmd", 32'(ocw2_cmd), 32'h20);

        // 4: ICW1 from READY restores defaults; ICW1 again from WAIT_ICW3
        cpu_write(1'b0, 8'h11);
        check("t4_icw1_imr", 32'(imr), 32'h5A);
        check("t4_icw1_smm", 32'(special_mask), 32'h0);
        check("t4_icw1_notready", 32'(init_done), 32'h0);
        cpu_write(1'b1, 8'h08);
        cpu_write(1'b0, 8'h11);
        check("t4_reicw1_stb", 32'(stb), 32'h40);
        cpu_write(1'b1, 8'h10);
        check("t4_back_icw2_stb", 32'(stb), 32'h20);
        check("t4_back_vector", 32'(vector_base), 32'h02);

        // IDLE ignores everything except ICW1
        do_reset();
        cpu_write(1'b1, 8'hFF);
        check("t4_idle_a1_stb", 32'(stb), 32'h00);
        check("t4_idle_imr", 32'(imr), 32'h5A);
        cpu_write(1'b0, 8'h20);
        check("t4_idle_a0_stb", 32'(stb), 32'h00);
        check("t4_idle_ocw2", 32'(ocw2_cmd), 32'h00);
        check("t4_idle_state", 32'(init_done), 32'h0);

        // 5: reset during a write is discarded
        cpu_write(1'b0, 8'h13);
        cpu_write(1'b1, 8'hF8);
        @(posedge clk);
        #1;
        bus.A0          = 1'b0;
        bus.data_bus_in = 8'h13;
        bus.CS_bar      = 1'b0;
        bus.WR_bar      = 1'b0;
        reset           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        bus.WR_bar = 1'b1;
        bus.CS_bar = 1'b1;
        begin
            logic [6:0] seen;
            seen = '0;
            repeat (3) begin
                @(posedge clk);
                #1;
                seen = seen | stb;
            end
            check("t5_no_strobe", 32'(seen), 32'h00);
        end
        check("t5_vector", 32'(vector_base), 32'h00);
        check("t5_flags", 32'({ltim, single, ic4, aeoi}), 32'h0);
        check("t5_imr", 32'(imr), 32'h5A);
        check("t5_init_done", 32'(init_done), 32'h0);

`ifdef BUS_CTRL_POLL_EN
        // 6: poll read
        cpu_write(1'b0, 8'h13);
        cpu_write(1'b1, 8'h20);
        cpu_write(1'b1, 8'h03);
        cpu_write(1'b0, 8'h0C);
        check("t6_ocw3_stb", 32'(stb), 32'h01);
        cpu_read(1'b0, rd_data, rd_oe);
        check("t6_poll_ack_early", 32'(poll_ack), 32'h0);
        check("t6_poll_word", 32'(rd_data), 32'h83);
        @(posedge clk);
        #1;
        check("t6_poll_ack", 32'(poll_ack), 32'h1);
        @(posedge clk);
        #1;
        check("t6_poll_ack_width", 32'(poll_ack), 32'h0);
        cpu_read(1'b0, rd_data, rd_oe);
        check("t6_after_poll_irr", 32'(rd_data), 32'h81);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
